// File: rtl/input_capture_mc_if.sv
// Signal bundle for input_capture_mc: pins, per-channel controls and capture results.
// o_ts exists only when IC_TIMESTAMP_EN is defined.
interface input_capture_mc_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 16
);
    logic [CH-1:0]       i_cap_pin;
    logic [2*CH-1:0]     i_edge_sel;
    logic [CH-1:0]       i_clr;
    logic                i_cnt_en;
    logic [CH-1:0]       i_flg_ack;
    // o_ic_pls is a one-cycle valid with no ready: an observer must sample it every cycle.
    logic [CH-1:0]       o_ic_pls;
    logic [CH-1:0]       o_ic_flg;
    logic [CH-1:0]       o_ovf;
    logic [CH*CNT_W-1:0] o_cnt;
`ifdef IC_TIMESTAMP_EN
    logic [CH*CNT_W-1:0] o_ts;

    modport master (
        output i_cap_pin, i_edge_sel, i_clr, i_cnt_en, i_flg_ack,
        input  o_ic_pls, o_ic_flg, o_ovf, o_cnt, o_ts
    );
    modport slave (
        input  i_cap_pin, i_edge_sel, i_clr, i_cnt_en, i_flg_ack,
        output o_ic_pls, o_ic_flg, o_ovf, o_cnt, o_ts
    );
`else
    modport master (
        output i_cap_pin, i_edge_sel, i_clr, i_cnt_en, i_flg_ack,
        input  o_ic_pls, o_ic_flg, o_ovf, o_cnt
    );
    modport slave (
        input  i_cap_pin, i_edge_sel, i_clr, i_cnt_en, i_flg_ack,
        output o_ic_pls, o_ic_flg, o_ovf, o_cnt
    );
`endif
endinterface

// File: rtl/input_capture_mc.sv
// Multi-channel input capture: synchronised edge detection, event counters, sticky flags.
// Optional per-channel timestamping against a shared timebase when IC_TIMESTAMP_EN is defined.
module input_capture_mc #(
    parameter int CH    = 4,
    parameter int CNT_W = 16
) (
    input  logic                 i_sysclk,
    input  logic                 i_sysrst,
    input_capture_mc_if.slave    io_bus
);
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CH-1:0]       r_sync0;
    logic [CH-1:0]       r_sync1;
    logic [CH-1:0]       r_sync2;
    logic [CH-1:0]       w_rise;
    logic [CH-1:0]       w_fall;
    logic [CH-1:0]       w_pls;
    logic [CNT_W-1:0]    r_cnt [CH];
    logic [CH-1:0]       r_flg;
    logic [CH-1:0]       r_ovf;
    logic [CH*CNT_W-1:0] w_cnt;

    // sync0 absorbs metastability; edges are judged between the two settled stages.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync0 <= io_bus.i_cap_pin;
            r_sync1 <= r_sync0;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_rise = r_sync1 & ~r_sync2;
        w_fall = ~r_sync1 & r_sync2;
        w_pls  = '0;
        for (int n = 0; n < CH; n++) begin
            case (io_bus.i_edge_sel[2*n +: 2])
                2'b01:   w_pls[n] = w_rise[n];
                2'b10:   w_pls[n] = w_fall[n];
                2'b11:   w_pls[n] = w_rise[n] | w_fall[n];
                default: w_pls[n] = 1'b0;
            endcase
        end
        if (!io_bus.i_cnt_en || i_sysrst) begin
            w_pls = '0;
        end
    end

    // Clear beats a same-cycle pulse; a pulse beats a same-cycle acknowledge.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            for (int n = 0; n < CH; n++) begin
                r_cnt[n] <= '0;
            end
            r_flg <= '0;
            r_ovf <= '0;
        end else begin
            for (int n = 0; n < CH; n++) begin
                if (io_bus.i_clr[n]) begin
                    r_cnt[n] <= '0;
                    r_flg[n] <= 1'b0;
                    r_ovf[n] <= 1'b0;
                end else if (w_pls[n]) begin
                    r_cnt[n] <= r_cnt[n] + C_ONE;
                    r_flg[n] <= 1'b1;
                    if (r_cnt[n] == {CNT_W{1'b1}}) begin
                        r_ovf[n] <= 1'b1;
                    end
                end else if (io_bus.i_flg_ack[n]) begin
                    r_flg[n] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int n = 0; n < CH; n++) begin
            w_cnt[n*CNT_W +: CNT_W] = r_cnt[n];
        end
    end

    assign io_bus.o_ic_pls = w_pls;
    assign io_bus.o_ic_flg = r_flg;
    assign io_bus.o_ovf    = r_ovf;
    assign io_bus.o_cnt    = w_cnt;

`ifdef IC_TIMESTAMP_EN
    logic [CNT_W-1:0]    r_tb;
    logic [CNT_W-1:0]    r_ts [CH];
    logic [CH*CNT_W-1:0] w_ts;

    // Timebase only advances while counting is enabled, so stamps are in enabled cycles.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_tb <= '0;
        end else if (io_bus.i_cnt_en) begin
            r_tb <= r_tb + C_ONE;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            for (int n = 0; n < CH; n++) begin
                r_ts[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CH; n++) begin
                if (io_bus.i_clr[n]) begin
                    r_ts[n] <= '0;
                end else if (w_pls[n]) begin
                    r_ts[n] <= r_tb;
                end
            end
        end
    end

    always_comb begin
        w_ts = '0;
        for (int n = 0; n < CH; n++) begin
            w_ts[n*CNT_W +: CNT_W] = r_ts[n];
        end
    end

    assign io_bus.o_ts = w_ts;
`endif

endmodule

// File: tb/tb_input_capture_mc.sv
// Directed bench for input_capture_mc: pulse scoreboard plus counter/flag checks.
// Timestamp checks are compiled only when IC_TIMESTAMP_EN is defined.
module tb_input_capture_mc;
    localparam int CH    = 4;
    localparam int CNT_W = 8;
    localparam int EXP_W = CH + 16;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;
    logic [CH-1:0]    prev_pin;

    input_capture_mc_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

    input_capture_mc #(.CH(CH), .CNT_W(CNT_W)) dut (
        .i_sysclk (clk),
        .i_sysrst (rst),
        .io_bus   (bus)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected pulse mask for a sampled pin change prev -> cur under current settings
    function automatic logic [CH-1:0] edge_mask(input logic [CH-1:0] p, input logic [CH-1:0] c);
        logic [CH-1:0] m;
        m = '0;
        for (int n = 0; n < CH; n++) begin
            case (bus.i_edge_sel[2*n +: 2])
                2'b01:   m[n] = c[n] & ~p[n];
                2'b10:   m[n] = ~c[n] & p[n];
                2'b11:   m[n] = c[n] ^ p[n];
                default: m[n] = 1'b0;
            endcase
        end
        if (!bus.i_cnt_en) m = '0;
        return m;
    endfunction

    function automatic logic [31:0] get_cnt(input int n);
        logic [31:0] r;
        r = '0;
        r[CNT_W-1:0] = bus.o_cnt[n*CNT_W +: CNT_W];
        return r;
    endfunction

`ifdef IC_TIMESTAMP_EN
    function automatic logic [31:0] get_ts(input int n);
        logic [31:0] r;
        r = '0;
        r[CNT_W-1:0] = bus.o_ts[n*CNT_W +: CNT_W];
        return r;
    endfunction
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // driver tasks
    task automatic set_pins(input logic [CH-1:0] v);
        logic [CH-1:0] m;
        m = edge_mask(prev_pin, v);
        if (m != '0) exp_q.push_back({16'(cyc + 2), m});
        bus.i_cap_pin = v;
        prev_pin = v;
        tick(1);
    endtask

    task automatic set_sel(input int n, input logic [1:0] mode);
        bus.i_edge_sel[2*n +: 2] = mode;
    endtask

    task automatic do_reset(input int n);
        logic [CH-1:0] m;
        rst = 1'b1;
        tick(1);
        chk("rst_pls", 32'(bus.o_ic_pls), 32'd0);
        chk("rst_flg", 32'(bus.o_ic_flg), 32'd0);
        chk("rst_ovf", 32'(bus.o_ovf), 32'd0);
        chk("rst_cnt", 32'(bus.o_cnt), 32'd0);
        tick(n - 1);
        rst = 1'b0;
        // sync stages restart from zero, so a held-high pin looks like a fresh rising edge
        m = edge_mask('0, bus.i_cap_pin);
        if (m != '0) exp_q.push_back({16'(cyc + 2), m});
        prev_pin = bus.i_cap_pin;
        tick(1);
    endtask

    // scoreboard monitor: compares the pulse vector against the queue head when due
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0][EXP_W-1:CH] <= 16'(cyc)) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e[EXP_W-1:CH] != 16'(cyc) || bus.o_ic_pls !== mon_e[CH-1:0]) begin
                errors++;
                $display("FAIL pulse: cycle %0d got %b, required %b in cycle %0d",
                         cyc, bus.o_ic_pls, mon_e[CH-1:0], mon_e[EXP_W-1:CH]);
            end
        end else if (bus.o_ic_pls !== '0) begin
            checks++;
            errors++;
            $display("FAIL pulse_unexpected: cycle %0d got %b, required 0", cyc, bus.o_ic_pls);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        prev_pin = '0;
        bus.i_cap_pin  = '0;
        bus.i_edge_sel = '0;
        bus.i_clr      = '0;
        bus.i_cnt_en   = 1'b1;
        bus.i_flg_ack  = '0;
        tick(1);
        do_reset(3);

        // rising edge latency on ch0
        set_sel(0, 2'b01);
        tick(1);
        set_pins(4'b0001);
        tick(1);
        chk("cnt0_before", get_cnt(0), 32'd0);
        tick(1);
        chk("cnt0_rise", get_cnt(0), 32'd1);
        chk("flg0_rise", 32'(bus.o_ic_flg[0]), 32'd1);
        bus.i_flg_ack = 4'b0001;
        tick(1);
        bus.i_flg_ack = '0;
        chk("flg0_ack", 32'(bus.o_ic_flg[0]), 32'd0);

        // both-edge mode, then falling-only mode, on ch1
        set_sel(1, 2'b11);
        tick(1);
        set_pins(4'b0011); set_pins(4'b0001); set_pins(4'b0011);
        set_pins(4'b0001); set_pins(4'b0011);
        tick(3);
        chk("cnt1_both", get_cnt(1), 32'd5);
        set_sel(1, 2'b00);
        set_pins(4'b0001);
        tick(2);
        bus.i_clr = 4'b0010;
        tick(1);
        bus.i_clr = '0;
        chk("cnt1_clr", get_cnt(1), 32'd0);
        set_sel(1, 2'b10);
        tick(1);
        set_pins(4'b0011); set_pins(4'b0001); set_pins(4'b0011);
        set_pins(4'b0001); set_pins(4'b0011);
        tick(3);
        chk("cnt1_fall", get_cnt(1), 32'd2);
        chk("flg1_fall", 32'(bus.o_ic_flg[1]), 32'd1);

        // wrap on ch2 with one pulse per cycle
        set_sel(2, 2'b11);
        tick(1);
        for (int i = 0; i < 255; i++) set_pins(prev_pin ^ 4'b0100);
        tick(3);
        chk("cnt2_full", get_cnt(2), 32'd255);
        chk("ovf2_full", 32'(bus.o_ovf[2]), 32'd0);
        set_pins(prev_pin ^ 4'b0100);
        tick(3);
        chk("cnt2_wrap", get_cnt(2), 32'd0);
        chk("ovf2_wrap", 32'(bus.o_ovf[2]), 32'd1);
        bus.i_clr = 4'b0100;
        tick(1);
        bus.i_clr = '0;
        chk("ovf2_clr", 32'(bus.o_ovf[2]), 32'd0);
        chk("flg2_clr", 32'(bus.o_ic_flg[2]), 32'd0);

        // pulse and acknowledge in the same cycle
        set_pins(prev_pin & 4'b1110);
        tick(2);
        set_pins(prev_pin | 4'b0001);
        tick(1);
        bus.i_flg_ack = 4'b0001;
        tick(1);
        bus.i_flg_ack = '0;
        chk("flg0_set_wins", 32'(bus.o_ic_flg[0]), 32'd1);
        chk("cnt0_ack", get_cnt(0), 32'd2);

        // pulse and clear in the same cycle
        set_pins(prev_pin & 4'b1110);
        tick(2);
        set_pins(prev_pin | 4'b0001);
        tick(1);
        bus.i_clr = 4'b0001;
        tick(1);
        bus.i_clr = '0;
        chk("cnt0_clr_wins", get_cnt(0), 32'd0);
        chk("flg0_clr_wins", 32'(bus.o_ic_flg[0]), 32'd0);

        // edges on all channels in one cycle
        bus.i_edge_sel = '0;
        set_pins(4'b0000);
        tick(2);
        bus.i_clr = 4'b1111;
        tick(1);
        bus.i_clr = '0;
        bus.i_edge_sel = 8'b01010101;
        tick(1);
        set_pins(4'b1111);
        tick(3);
        for (int n = 0; n < CH; n++) chk($sformatf("cnt%0d_all", n), get_cnt(n), 32'd1);
        chk("flg_all", 32'(bus.o_ic_flg), 32'hf);

        // count enable low blocks ten edges
        set_sel(0, 2'b11);
        tick(1);
        bus.i_cnt_en = 1'b0;
        for (int i = 0; i < 10; i++) set_pins(prev_pin ^ 4'b0001);
        tick(3);
        bus.i_cnt_en = 1'b1;
        chk("cnt0_disabled", get_cnt(0), 32'd1);

        // reset mid-operation with pins held high
        do_reset(2);
        tick(2);
        for (int n = 0; n < CH; n++) chk($sformatf("cnt%0d_after_rst", n), get_cnt(n), 32'd1);

`ifdef IC_TIMESTAMP_EN
        // timestamp of a ch3 pulse in cycle 20 after enable rises
        bus.i_cnt_en = 1'b0;
        set_pins(4'b0000);
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        bus.i_cnt_en = 1'b1;
        tick(18);
        set_pins(4'b1000);
        tick(2);
        chk("ts3_stamp", get_ts(3), 32'd20);
        tick(5);
        chk("ts3_hold", get_ts(3), 32'd20);
        chk("ts0_idle", get_ts(0), 32'd0);
        bus.i_clr = 4'b1000;
        tick(1);
        bus.i_clr = '0;
        chk("ts3_clr", get_ts(3), 32'd0);
`endif

        tick(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
